// File: rtl/timer_counter_core.sv
// rtl/timer_counter_core.sv - general purpose timer/counter with prescaler, two compares and one-shot mode
//
// Purpose:
//   Up-counter with three run modes: free-run, clear-on-match0 (CTC) and one-shot.
//   A small IDLE/RUN/DONE FSM gates counting. An optional prescaler divides the tick rate.
//   Sticky event flags are cleared by write-1-to-clear pulses. They feed a single
//   level interrupt.
//
// Configuration:
//   TIMER_CORE_MATCH1_EN - when defined, implements the match1 compare, match1_flag,
//                          out_match1 and the match1 interrupt term. When undefined,
//                          those outputs are tied 0 and match1_val / irq_clr[1] are ignored.
//
// Parameters:
//   CNT_W      counter / compare width
//   PRESC_DIV  prescaler divide ratio used when clock_select=1 (2..256)
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   start               run enable
//   clock_select        0 = tick every clk, 1 = tick every PRESC_DIV clks
//   operation_mode      000 free-run, 001 CTC, 010 one-shot, others as 000
//   cnt_max             top value
//   match0_val          compare value 0
//   match1_val          compare value 1
//   overflow_int_en     interrupt enable for overflow_flag
//   out_match_0_int_en  interrupt enable for match0_flag
//   out_match_1_int_en  interrupt enable for match1_flag
//   irq_clr             W1C pulses: [0] match0, [1] match1, [2] overflow
//   count               current count
//   overflow_flag       sticky overflow event
//   match0_flag         sticky match0 event
//   match1_flag         sticky match1 event
//   out_match0          toggles on each match0 tick
//   out_match1          toggles on each match1 tick
//   irq                 OR of enabled flags
//   busy                high while the FSM is in RUN

module timer_counter_core #(
  parameter int CNT_W     = 8,
  parameter int PRESC_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clock_select,
  input  logic [2:0]       operation_mode,
  input  logic [CNT_W-1:0] cnt_max,
  input  logic [CNT_W-1:0] match0_val,
  input  logic [CNT_W-1:0] match1_val,
  input  logic             overflow_int_en,
  input  logic             out_match_0_int_en,
  input  logic             out_match_1_int_en,
  input  logic [2:0]       irq_clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow_flag,
  output logic             match0_flag,
  output logic             match1_flag,
  output logic             out_match0,
  output logic             out_match1,
  output logic             irq,
  output logic             busy
);

  localparam int PW = $clog2(PRESC_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic             run_active;
  logic             tick;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_set;
  logic             oneshot_end;
  logic             m0_hit;

  // Counting happens only in RUN with start still high. On the cycle start drops, the
  // FSM leaves RUN with the count frozen.
  assign run_active = (state == RUN) && start;
  assign tick       = run_active && (!clock_select || (presc == PRESC_LAST));
  assign m0_hit     = tick && (count == match0_val);

  always_comb begin
    cnt_nxt     = count;
    ovf_set     = 1'b0;
    oneshot_end = 1'b0;
    if (tick) begin
      case (operation_mode)
        3'b001: begin
          // CTC: match0 takes precedence and never flags overflow.
          if (count == match0_val) begin
            cnt_nxt = '0;
          end else if (count == cnt_max) begin
            cnt_nxt = '0;
            ovf_set = 1'b1;
          end else begin
            cnt_nxt = count + CNT_ONE;
          end
        end
        3'b010: begin
          // One-shot: stop at top and hold the terminal value.
          if (count == cnt_max) begin
            ovf_set     = 1'b1;
            oneshot_end = 1'b1;
          end else begin
            cnt_nxt = count + CNT_ONE;
          end
        end
        default: begin
          // Free-run; the reserved encodings behave the same way. A count above a
          // lowered cnt_max simply wraps through zero without flagging overflow.
          if (count == cnt_max) begin
            cnt_nxt = '0;
            ovf_set = 1'b1;
          end else begin
            cnt_nxt = count + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      presc         <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
      match0_flag   <= 1'b0;
      out_match0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          count <= cnt_nxt;
          // With clock_select=0 the prescaler holds its value instead of clearing.
          if (run_active && clock_select) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_ONE;
          end
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (oneshot_end) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          presc <= '0;
          if (!start) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          presc <= '0;
        end
      endcase

      // A set on the same cycle as a clear wins.
      overflow_flag <= ovf_set | (overflow_flag & ~irq_clr[2]);
      match0_flag   <= m0_hit  | (match0_flag   & ~irq_clr[0]);
      if (m0_hit) begin
        out_match0 <= ~out_match0;
      end
    end
  end

`ifdef TIMER_CORE_MATCH1_EN
  logic m1_hit;

  assign m1_hit = tick && (count == match1_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      match1_flag <= 1'b0;
      out_match1  <= 1'b0;
    end else begin
      match1_flag <= m1_hit | (match1_flag & ~irq_clr[1]);
      if (m1_hit) begin
        out_match1 <= ~out_match1;
      end
    end
  end

  assign irq = (overflow_flag & overflow_int_en) |
               (match0_flag   & out_match_0_int_en) |
               (match1_flag   & out_match_1_int_en);
`else
  logic unused_match1;

  assign unused_match1 = ^{match1_val, irq_clr[1], out_match_1_int_en};
  assign match1_flag   = 1'b0;
  assign out_match1    = 1'b0;
  assign irq = (overflow_flag & overflow_int_en) |
               (match0_flag   & out_match_0_int_en);
`endif

endmodule

// File: tb/tb_timer_counter_core.sv
// tb/tb_timer_counter_core.sv - directed self-checking bench for timer_counter_core

module tb_timer_counter_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clock_select;
  logic [2:0] operation_mode;
  logic [7:0] cnt_max;
  logic [7:0] match0_val;
  logic [7:0] match1_val;
  logic       overflow_int_en;
  logic       out_match_0_int_en;
  logic       out_match_1_int_en;
  logic [2:0] irq_clr;
  logic [7:0] count;
  logic       overflow_flag;
  logic       match0_flag;
  logic       match1_flag;
  logic       out_match0;
  logic       out_match1;
  logic       irq;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  timer_counter_core #(.CNT_W(8), .PRESC_DIV(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .clock_select       (clock_select),
    .operation_mode     (operation_mode),
    .cnt_max            (cnt_max),
    .match0_val         (match0_val),
    .match1_val         (match1_val),
    .overflow_int_en    (overflow_int_en),
    .out_match_0_int_en (out_match_0_int_en),
    .out_match_1_int_en (out_match_1_int_en),
    .irq_clr            (irq_clr),
    .count              (count),
    .overflow_flag      (overflow_flag),
    .match0_flag        (match0_flag),
    .match1_flag        (match1_flag),
    .out_match0         (out_match0),
    .out_match1         (out_match1),
    .irq                (irq),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    start              = 1'b0;
    clock_select       = 1'b0;
    operation_mode     = 3'b000;
    cnt_max            = 8'd5;
    match0_val         = 8'd200;
    match1_val         = 8'd200;
    overflow_int_en    = 1'b0;
    out_match_0_int_en = 1'b0;
    out_match_1_int_en = 1'b0;
    irq_clr            = 3'b000;
    step(2);
    rst = 1'b0;

    check("rst_count", count, 0);
    check("rst_ovf", overflow_flag, 0);
    check("rst_m0", match0_flag, 0);
    check("rst_m1", match1_flag, 0);
    check("rst_out0", out_match0, 0);
    check("rst_out1", out_match1, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);

    // Free-run, cnt_max=5, one tick per clk.
    start = 1'b1;
    step(1);
    check("fr_enter_busy", busy, 1);
    check("fr_enter_count", count, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("fr_count", count, i % 6);
      check("fr_ovf", overflow_flag, (i >= 6) ? 1 : 0);
    end
    // Pause: count holds at 4 while IDLE.
    start = 1'b0;
    step(1);
    check("pause_busy", busy, 0);
    check("pause_count", count, 4);
    step(2);
    check("pause_hold", count, 4);
    start = 1'b1;
    step(1);
    check("resume_busy", busy, 1);
    check("resume_count", count, 4);
    step(1);
    check("resume_tick", count, 5);

    // Prescaled: 24 RUN cycles at divide-by-8 give 3 ticks.
    do_reset();
    clock_select = 1'b1;
    cnt_max      = 8'd255;
    start        = 1'b1;
    step(1);
    step(23);
    check("presc_before", count, 2);
    step(1);
    check("presc_count", count, 3);
    check("presc_busy", busy, 1);

    // CTC on match0=3.
    do_reset();
    clock_select       = 1'b0;
    operation_mode     = 3'b001;
    match0_val         = 8'd3;
    cnt_max            = 8'd10;
    out_match_0_int_en = 1'b1;
    start              = 1'b1;
    step(1);
    step(3);
    check("ctc_count3", count, 3);
    check("ctc_noflag", match0_flag, 0);
    step(1);
    check("ctc_wrap", count, 0);
    check("ctc_m0flag", match0_flag, 1);
    check("ctc_out0_a", out_match0, 1);
    check("ctc_irq", irq, 1);
    step(4);
    check("ctc_out0_b", out_match0, 0);
    check("ctc_count_b", count, 0);
    check("ctc_noovf", overflow_flag, 0);
    irq_clr = 3'b001;
    step(1);
    irq_clr = 3'b000;
    check("ctc_clr_flag", match0_flag, 0);
    check("ctc_clr_irq", irq, 0);
    check("ctc_clr_count", count, 1);

    // One-shot to 4.
    do_reset();
    out_match_0_int_en = 1'b0;
    operation_mode     = 3'b010;
    match0_val         = 8'd200;
    cnt_max            = 8'd4;
    start              = 1'b1;
    step(1);
    step(4);
    check("os_count4", count, 4);
    check("os_busy_run", busy, 1);
    step(1);
    check("os_hold", count, 4);
    check("os_busy_done", busy, 0);
    check("os_ovf", overflow_flag, 1);
    step(2);
    check("os_done_hold", count, 4);
    start = 1'b0;
    step(1);
    check("os_idle_count", count, 0);
    check("os_idle_ovf", overflow_flag, 1);

    // Reset mid-run at count 7 with start held high.
    do_reset();
    operation_mode = 3'b000;
    cnt_max        = 8'd255;
    match0_val     = 8'd3;
    start          = 1'b1;
    step(1);
    step(7);
    check("mr_count7", count, 7);
    check("mr_m0_set", match0_flag, 1);
    rst = 1'b1;
    step(1);
    check("mr_count", count, 0);
    check("mr_m0", match0_flag, 0);
    check("mr_out0", out_match0, 0);
    check("mr_busy", busy, 0);
    rst = 1'b0;
    step(1);
    check("mr_rerun_busy", busy, 1);
    check("mr_rerun_count", count, 0);
    step(1);
    check("mr_rerun_tick", count, 1);

    // Clear coincident with overflow set; match1 absent in the default build.
    do_reset();
    cnt_max            = 8'd2;
    match0_val         = 8'd200;
    match1_val         = 8'd1;
    out_match_1_int_en = 1'b1;
    start              = 1'b1;
    step(1);
    step(2);
    check("sc_count2", count, 2);
    irq_clr = 3'b100;
    step(1);
    check("sc_ovf_kept", overflow_flag, 1);
    check("sc_count0", count, 0);
    check("sc_m1flag", match1_flag, 0);
    check("sc_out1", out_match1, 0);
    check("sc_irq", irq, 0);
    step(1);
    irq_clr = 3'b000;
    check("sc_ovf_cleared", overflow_flag, 0);
    check("sc_count1", count, 1);
    out_match_1_int_en = 1'b0;

    // cnt_max=0: count stuck at 0, overflow on every tick.
    do_reset();
    cnt_max = 8'd0;
    start   = 1'b1;
    step(1);
    step(1);
    check("z_count", count, 0);
    check("z_ovf", overflow_flag, 1);
    irq_clr = 3'b100;
    step(1);
    irq_clr = 3'b000;
    check("z_ovf_reset", overflow_flag, 1);
    check("z_count2", count, 0);

    // Lowering cnt_max below count: wrap through 255 with no overflow.
    do_reset();
    cnt_max = 8'd255;
    start   = 1'b1;
    step(1);
    step(5);
    check("lw_count5", count, 5);
    cnt_max = 8'd2;
    step(251);
    check("lw_wrap_count", count, 0);
    check("lw_wrap_noovf", overflow_flag, 0);
    step(3);
    check("lw_top_count", count, 0);
    check("lw_top_ovf", overflow_flag, 1);
    overflow_int_en = 1'b1;
    #1;
    check("lw_irq", irq, 1);
    overflow_int_en = 1'b0;

    // Reserved mode behaves as free-run: no clear at match0.
    do_reset();
    operation_mode = 3'b111;
    match0_val     = 8'd1;
    cnt_max        = 8'd5;
    start          = 1'b1;
    step(1);
    step(3);
    check("rsv_count", count, 3);
    check("rsv_m0", match0_flag, 1);

    // Mode change mid-run to CTC takes effect on the next tick.
    operation_mode = 3'b001;
    match0_val     = 8'd4;
    step(1);
    check("mc_count4", count, 4);
    step(1);
    check("mc_ctc_clear", count, 0);
    check("mc_noovf", overflow_flag, 0);

    // clock_select switch mid-run: prescaler keeps its phase.
    do_reset();
    operation_mode = 3'b000;
    cnt_max        = 8'd255;
    clock_select   = 1'b1;
    start          = 1'b1;
    step(1);
    step(5);
    clock_select = 1'b0;
    step(2);
    check("cs_fast", count, 2);
    clock_select = 1'b1;
    step(2);
    check("cs_slow_pre", count, 2);
    step(1);
    check("cs_slow_tick", count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
